// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states and control-strobe bit positions for mini-SRISC
package cpu_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;
  localparam int D_PC = 0, D_ZLO = 1, D_ZHI = 2, D_MDR = 3, D_HI = 4, D_LO = 5, D_IN = 6, D_C = 7, D_R = 8;
  localparam int L_PC = 0, L_MAR = 1, L_MDR = 2, L_IR = 3, L_Y = 4, L_ZLO = 5, L_ZHI = 6, L_HI = 7,
                 L_LO = 8, L_CON = 9, L_OUT = 10, L_R = 11;
  localparam int G_A = 2, G_B = 1, G_C = 0;
  typedef struct packed {
    logic [8:0]  drv;
    logic [11:0] ld;
    logic [2:0]  gsel;
    logic        ba_out;
    logic        r15_in;
    logic        inc_pc;
    logic        read;
    logic        ram_we;
  } strobes_t;
endpackage

// File: rtl/cu_step_decode.sv
// cu_step_decode: combinational (state, opcode, con_ff) -> datapath strobes; CU_MULDIV_EN enables mul/div sequences
module cu_step_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  input  logic            con_ff,
  output strobes_t        s,
  output logic [OP_W-1:0] alu_op,
  output logic            last
);
  logic [4:0] opc;
  logic ralu, imm, ldi, ld, st, neg, br, jr, jal, mfhi, mflo, inp, outp, md, addr;
  state_t last_st;
  assign opc  = 5'(op);
  assign ralu = opc inside {[OP_ADD:OP_SHL]};
  assign imm  = opc inside {[OP_ADDI:OP_ORI]};
  assign ldi  = opc == OP_LDI;
  assign ld   = opc == OP_LD;
  assign st   = opc == OP_ST;
  assign neg  = opc == OP_NEG || opc == OP_NOT;
  assign br   = opc == OP_BR;
  assign jr   = opc == OP_JR;
  assign jal  = opc == OP_JAL;
  assign mfhi = opc == OP_MFHI;
  assign mflo = opc == OP_MFLO;
  assign inp  = opc == OP_IN;
  assign outp = opc == OP_OUT;
`ifdef CU_MULDIV_EN
  assign md   = opc == OP_DIV || opc == OP_MUL;
`else
  assign md   = 1'b0;
`endif
  assign addr = ld || st || ldi || br;
  // anything not classified (nop, halt, unassigned) ends at T3
  assign last_st = (ld || st) ? S_T7 : (br || md) ? S_T6 : (ralu || imm || ldi) ? S_T5 :
                   (jal || neg) ? S_T4 : S_T3;
  assign last = state == last_st;
  assign alu_op = (state inside {[S_T3:S_T7]}) ? (addr ? OP_W'(OP_ADD) : op) :
                  (state inside {[S_T0:S_T2]}) ? OP_W'(OP_ADD) : '0;
  always_comb begin
    s = '0;
    case (state)
      S_T0: begin s.drv[D_PC] = 1'b1; s.ld[L_MAR] = 1'b1; s.ld[L_ZLO] = 1'b1; s.inc_pc = 1'b1; end
      S_T1: begin s.drv[D_ZLO] = 1'b1; s.ld[L_PC] = 1'b1; s.ld[L_MDR] = 1'b1; s.read = 1'b1; end
      S_T2: begin s.drv[D_MDR] = 1'b1; s.ld[L_IR] = 1'b1; end
      S_T3: begin
        if (ralu || imm || md) begin s.gsel[G_B] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_Y] = 1'b1; end
        if (ld || st || ldi) begin s.gsel[G_B] = 1'b1; s.ba_out = 1'b1; s.ld[L_Y] = 1'b1; end
        if (neg) begin s.gsel[G_B] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_ZLO] = 1'b1; end
        if (br) begin s.gsel[G_A] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_CON] = 1'b1; end
        if (jr) begin s.gsel[G_A] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_PC] = 1'b1; end
        if (jal) begin s.drv[D_PC] = 1'b1; s.r15_in = 1'b1; end
        if (mfhi) begin s.drv[D_HI] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (mflo) begin s.drv[D_LO] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (inp) begin s.drv[D_IN] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (outp) begin s.gsel[G_A] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_OUT] = 1'b1; end
      end
      S_T4: begin
        if (ralu || md) begin s.gsel[G_C] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_ZLO] = 1'b1; end
        if (md) s.ld[L_ZHI] = 1'b1;
        if (imm || ldi || ld || st) begin s.drv[D_C] = 1'b1; s.ld[L_ZLO] = 1'b1; end
        if (neg) begin s.drv[D_ZLO] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (br) begin s.drv[D_PC] = 1'b1; s.ld[L_Y] = 1'b1; end
        if (jal) begin s.gsel[G_A] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_PC] = 1'b1; end
      end
      S_T5: begin
        if (ralu || imm || ldi) begin s.drv[D_ZLO] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (ld || st) begin s.drv[D_ZLO] = 1'b1; s.ld[L_MAR] = 1'b1; end
        if (br) begin s.drv[D_C] = 1'b1; s.ld[L_ZLO] = 1'b1; end
        if (md) begin s.drv[D_ZLO] = 1'b1; s.ld[L_LO] = 1'b1; end
      end
      S_T6: begin
        if (ld) begin s.read = 1'b1; s.ld[L_MDR] = 1'b1; end
        if (st) begin s.gsel[G_A] = 1'b1; s.drv[D_R] = 1'b1; s.ld[L_MDR] = 1'b1; end
        if (br && con_ff) begin s.drv[D_ZLO] = 1'b1; s.ld[L_PC] = 1'b1; end
        if (md) begin s.drv[D_ZHI] = 1'b1; s.ld[L_HI] = 1'b1; end
      end
      S_T7: begin
        if (ld) begin s.drv[D_MDR] = 1'b1; s.gsel[G_A] = 1'b1; s.ld[L_R] = 1'b1; end
        if (st) s.ram_we = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/execute sequencer for mini-SRISC; define CU_MULDIV_EN for mul/div sequences
module control_unit
  import cpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic [8:0]      drv,
  output logic [11:0]     ld,
  output logic [2:0]      gsel,
  output logic            ba_out,
  output logic            r15_in,
  output logic            inc_pc,
  output logic            read,
  output logic            ram_we,
  output logic [OP_W-1:0] alu_op,
  output logic            run
);
  state_t state, nxt;
  strobes_t s;
  logic [OP_W-1:0] op;
  logic last, unused_ir;
  assign op = ir[31 -: OP_W];
  assign unused_ir = ^ir[31-OP_W:0];
  cu_step_decode #(.OP_W(OP_W)) u_dec (
    .state  (state),
    .op     (op),
    .con_ff (con_ff),
    .s      (s),
    .alu_op (alu_op),
    .last   (last)
  );
  assign drv    = s.drv;
  assign ld     = s.ld;
  assign gsel   = s.gsel;
  assign ba_out = s.ba_out;
  assign r15_in = s.r15_in;
  assign inc_pc = s.inc_pc;
  assign read   = s.read;
  assign ram_we = s.ram_we;
  assign run    = state != S_HALT && state != S_RESET;
  // halt opcode always ends at T3, so testing it only on the last step is enough
  always_comb begin
    nxt = state;
    if (state == S_RESET) nxt = S_T0;
    else if (state != S_HALT) nxt = !last ? state_t'(state + 4'd1) :
                                    (stop || op == OP_W'(OP_HALT)) ? S_HALT : S_T0;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= S_RESET;
    else state <= nxt;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit; honours CU_MULDIV_EN
module tb_control_unit;
  typedef struct {
    int          tag;
    string       nm;
    logic [34:0] v;
    logic [34:0] m;
  } entry_t;
  localparam logic [34:0] ALL = {35{1'b1}};
  localparam logic [34:0] NA  = {1'b1, 5'b0, 29'h1FFFFFFF};
  localparam logic [8:0] PCO = 9'h001, ZLO = 9'h002, ZHO = 9'h004, MDRO = 9'h008, HIO = 9'h010,
                         RO = 9'h100, CO = 9'h080;
  localparam logic [11:0] PCI = 12'h001, MARI = 12'h002, MDRI = 12'h004, IRI = 12'h008, YI = 12'h010,
                          ZLI = 12'h020, ZHI = 12'h040, HII = 12'h080, LOI = 12'h100, CONI = 12'h200,
                          RI = 12'h800;
  localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
  logic clk = 1'b0, clr = 1'b1, con_ff = 1'b0, stop = 1'b0;
  logic [31:0] ir = '0;
  logic [8:0] drv;
  logic [11:0] ld;
  logic [2:0] gsel;
  logic ba_out, r15_in, inc_pc, read, ram_we, run;
  logic [4:0] alu_op;
  logic [34:0] obs;
  int cyc = 0, base = 0, checks = 0, errors = 0;
  entry_t q[$];
  entry_t e;
  control_unit dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .stop(stop), .drv(drv), .ld(ld), .gsel(gsel),
    .ba_out(ba_out), .r15_in(r15_in), .inc_pc(inc_pc), .read(read), .ram_we(ram_we), .alu_op(alu_op),
    .run(run)
  );
  assign obs = {run, alu_op, drv, ld, gsel, ba_out, r15_in, inc_pc, read, ram_we};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [34:0] ov(logic r, logic [4:0] a, logic [8:0] d, logic [11:0] l, logic [2:0] g,
                                     logic b, logic r15, logic inc, logic rd, logic we);
    return {r, a, d, l, g, b, r15, inc, rd, we};
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && q[0].tag <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.tag != cyc) begin
        errors++;
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", e.nm, e.tag, cyc);
      end else if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.nm, obs & e.m, e.v & e.m, cyc);
      end
    end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input int k, input string nm, input logic [34:0] v, input logic [34:0] m);
    q.push_back('{base + k, nm, v, m});
  endtask
  task automatic fetch(input logic [31:0] i, input logic c, input logic s);
    ir = i; con_ff = c; stop = s; base = cyc;
    chk(0, "t0", ov(1, 5'd3, PCO, MARI | ZLI, 3'b0, 0, 0, 1, 0, 0), ALL);
    chk(1, "t1", ov(1, 0, ZLO, PCI | MDRI, 3'b0, 0, 0, 0, 1, 0), NA);
    chk(2, "t2", ov(1, 0, MDRO, IRI, 3'b0, 0, 0, 0, 0, 0), NA);
  endtask
  task automatic ldst_front(input string p);
    chk(3, {p, "_t3"}, ov(1, 0, 9'h0, YI, GB, 1, 0, 0, 0, 0), NA);
    chk(4, {p, "_t4"}, ov(1, 5'd3, CO, ZLI, 3'b0, 0, 0, 0, 0, 0), ALL);
    chk(5, {p, "_t5"}, ov(1, 0, ZLO, MARI, 3'b0, 0, 0, 0, 0, 0), NA);
  endtask
  initial begin
    tick(2);
    base = cyc;
    chk(0, "reset", '0, ALL);
    @(negedge clk); #1 clr = 1'b0;
    tick(1);
    fetch(32'h0000_0000, 0, 0);
    ldst_front("ld");
    chk(6, "ld_t6", ov(1, 0, 9'h0, MDRI, 3'b0, 0, 0, 0, 1, 0), NA);
    chk(7, "ld_t7", ov(1, 0, MDRO, RI, GA, 0, 0, 0, 0, 0), NA);
    tick(8);
    fetch(32'h1000_0000, 0, 0);
    ldst_front("st");
    chk(6, "st_t6", ov(1, 0, RO, MDRI, GA, 0, 0, 0, 0, 0), NA);
    chk(7, "st_t7", ov(1, 0, 9'h0, 12'h0, 3'b0, 0, 0, 0, 0, 1), NA);
    tick(8);
    for (int c = 1; c >= 0; c--) begin
      fetch(32'h9A00_0000, c[0], 0);
      chk(3, "br_t3", ov(1, 0, RO, CONI, GA, 0, 0, 0, 0, 0), NA);
      chk(4, "br_t4", ov(1, 0, PCO, YI, 3'b0, 0, 0, 0, 0, 0), NA);
      chk(5, "br_t5", ov(1, 5'd3, CO, ZLI, 3'b0, 0, 0, 0, 0, 0), ALL);
      chk(6, c ? "br_t6_taken" : "br_t6_idle",
          c ? ov(1, 0, ZLO, PCI, 3'b0, 0, 0, 0, 0, 0) : ov(1, 0, 9'h0, 12'h0, 3'b0, 0, 0, 0, 0, 0), NA);
      tick(7);
    end
    fetch(32'h2000_0000, 0, 0);
    chk(3, "sub_t3", ov(1, 0, RO, YI, GB, 0, 0, 0, 0, 0), NA);
    chk(4, "sub_t4", ov(1, 5'b00100, RO, ZLI, GC, 0, 0, 0, 0, 0), ALL);
    chk(5, "sub_t5", ov(1, 0, ZLO, RI, GA, 0, 0, 0, 0, 0), NA);
    tick(6);
    fetch(32'h8800_0000, 0, 0);
    chk(3, "neg_t3", ov(1, 0, RO, ZLI, GB, 0, 0, 0, 0, 0), NA);
    chk(4, "neg_t4", ov(1, 0, ZLO, RI, GA, 0, 0, 0, 0, 0), NA);
    tick(5);
    fetch(32'h6000_0000, 0, 0);
    chk(3, "addi_t3", ov(1, 0, RO, YI, GB, 0, 0, 0, 0, 0), NA);
    chk(4, "addi_t4", ov(1, 5'b01100, CO, ZLI, 3'b0, 0, 0, 0, 0, 0), ALL);
    chk(5, "addi_t5", ov(1, 0, ZLO, RI, GA, 0, 0, 0, 0, 0), NA);
    tick(6);
    fetch(32'hA800_0000, 0, 0);
    chk(3, "jal_t3", ov(1, 0, PCO, 12'h0, 3'b0, 0, 1, 0, 0, 0), NA);
    chk(4, "jal_t4", ov(1, 0, RO, PCI, GA, 0, 0, 0, 0, 0), NA);
    tick(5);
    fetch(32'hC000_0000, 0, 0);
    chk(3, "mfhi_t3", ov(1, 0, HIO, RI, GA, 0, 0, 0, 0, 0), NA);
    tick(4);
    fetch(32'h8000_0000, 0, 0);
`ifdef CU_MULDIV_EN
    chk(3, "mul_t3", ov(1, 0, RO, YI, GB, 0, 0, 0, 0, 0), NA);
    chk(4, "mul_t4", ov(1, 0, RO, ZLI | ZHI, GC, 0, 0, 0, 0, 0), NA);
    chk(5, "mul_t5", ov(1, 0, ZLO, LOI, 3'b0, 0, 0, 0, 0, 0), NA);
    chk(6, "mul_t6", ov(1, 0, ZHO, HII, 3'b0, 0, 0, 0, 0, 0), NA);
    tick(7);
`else
    chk(3, "mul_t3_idle", ov(1, 0, 9'h0, 12'h0, 3'b0, 0, 0, 0, 0, 0), NA);
    tick(4);
`endif
    fetch(32'h0000_0000, 0, 0);
    tick(5);
    clr = 1'b1;
    chk(5, "clr_abort", '0, ALL);
    @(negedge clk); #1 clr = 1'b0;
    tick(1);
    fetch(32'hD800_0000, 0, 0);
    chk(3, "halt_t3", ov(1, 0, 9'h0, 12'h0, 3'b0, 0, 0, 0, 0, 0), NA);
    for (int k = 4; k < 24; k++) chk(k, "halt_hold", '0, NA);
    tick(24);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    fetch(32'h1800_0000, 0, 1);
    chk(3, "add_t3", ov(1, 0, RO, YI, GB, 0, 0, 0, 0, 0), NA);
    chk(4, "add_t4", ov(1, 5'd3, RO, ZLI, GC, 0, 0, 0, 0, 0), ALL);
    chk(5, "add_t5", ov(1, 0, ZLO, RI, GA, 0, 0, 0, 0, 0), NA);
    chk(6, "stop_halt", '0, NA);
    chk(7, "stop_hold", '0, NA);
    tick(8);
    stop = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never sampled, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time 100000");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the mini-SRISC datapath. It steps through fetch (T0–T2) and a per-opcode execute sequence (T3–T7). In every state it drives the datapath's bus-driver, register-load, register-select and memory strobes from the opcode in IR and the CON flip-flop. It sits beside the datapath top and replaces testbench-driven control.

## Interface
Parameters:
- `OP_W`, default 5, opcode width (`ir[31:27]`).

Ports:
- `clk`  in  1  system clock, all state changes on rising edge
- `clr`  in  1  asynchronous, active-high reset
- `ir`  in  32  instruction register contents; opcode = `ir[31:27]`
- `con_ff`  in  1  branch condition from CON FF
- `stop`  in  1  request halt at next instruction boundary
- `drv`  out  9  one-hot bus driver
  - bit 0 PCout, 1 ZLowout, 2 ZHighout, 3 MDRout, 4 HIout, 5 LOout, 6 InPortout, 7 Cout, 8 Rout
- `ld`  out  12  register loads
  - bit 0 PCin, 1 MARin, 2 MDRin, 3 IRin, 4 Yin, 5 ZLowIn, 6 ZHighIn, 7 HIin, 8 LOin, 9 CONin, 10 OutPortIn, 11 Rin
- `gsel`  out  3  {Gra, Grb, Grc}, at most one set
- `ba_out`  out  1  BAout (Rout variant: R0 reads as 0)
- `r15_in`  out  1  direct load of R15 (jal link)
- `inc_pc`  out  1  IncPC, ALU adds 1
- `read`  out  1  memory read into MDR
- `ram_we`  out  1  memory write
- `alu_op`  out  5  ALU operation: ADD (`5'b00011`) in address/branch states, otherwise opcode
- `run`  out  1  high in every state except HALT and RESET

## Operation
- States: RESET, T0..T7, HALT. Outputs are a combinational decode of state and opcode, so every strobe is valid for exactly one cycle.
- Fetch, every instruction:
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: ZLowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute (ops: ld 00000, ldi 00001, st 00010, add..shl 00011–01011, addi/andi/ori 01100–01110, div 01111, mul 10000, neg 10001, not 10010, br 10011, jr 10100, jal 10101, in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011):
  - R-ALU: T3 Grb Rout Yin; T4 Grc Rout ZLowIn; T5 ZLowout Gra Rin.
  - neg/not: T3 Grb Rout ZLowIn; T4 ZLowout Gra Rin.
  - Immediate: T3 Grb Rout Yin; T4 Cout ZLowIn; T5 ZLowout Gra Rin.
  - ldi: as immediate but T3 uses BAout.
  - ld: T3 Grb BAout Yin; T4 Cout ZLowIn (ADD); T5 ZLowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st: T3–T5 as ld; T6 Gra Rout MDRin; T7 ram_we.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ZLowIn (ADD); T6 ZLowout PCin only if `con_ff`, otherwise T6 idle.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout r15_in; T4 Gra Rout PCin.
  - mfhi/mflo: T3 HIout/LOout Gra Rin.
  - in: T3 InPortout Gra Rin.
  - out: T3 Gra Rout OutPortIn.
  - nop: T3 idle.
  - halt: T3 → HALT.
- Unassigned opcodes execute as nop.
- The last state of each sequence returns to T0, or to HALT if `stop` is sampled high in that state.
- HALT is sticky; only `clr` exits it.

## Timing
- On `clr`: state = RESET, all outputs 0 immediately (asynchronous). RESET → T0 on the first edge after `clr` falls.
- Reset mid-instruction aborts it. `ram_we` and `ld` drop combinationally, so no partial write completes after `clr` rises.
- Memory is single-cycle: data is valid in the same state Read is asserted.
- `ir` is sampled from T3 onward, i.e. after the IRin edge at the end of T2.
- Instruction latency in cycles: nop/jr/mf*/in/out/halt 4, jal/neg/not 5, R-ALU/imm/ldi 6, br 7, ld/st 8.
- Invariants: `drv` is zero or one-hot; `ba_out` is never set together with `drv[8]`; Rin and CONin are never set together.

## Configuration
- `CU_MULDIV_EN` defined: mul/div run T3 Grb Rout Yin; T4 Grc Rout ZLowIn ZHighIn; T5 ZLowout LOin; T6 ZHighout HIin. Latency 7.
- `CU_MULDIV_EN` undefined: opcodes 01111/10000 execute as nop.

## Structure
- Shared package `cpu_pkg`:
  - opcode localparams
  - state enum (RESET, T0..T7, HALT)
  - `drv`/`ld` bit-index constants
- One natural sub-module, `cu_step_decode`: purely combinational (state, opcode, con_ff) → strobes. The top holds only the state register and next-state logic.

## Test plan
- Reset then `ir`=0 during fetch → T0 shows `drv`=PCout, `ld`={MARin, ZLowIn}, `inc_pc`=1; T2 shows MDRout+IRin.
- `ir`=32'h9A000000 (br, Ra=4), `con_ff`=1 → T6 shows ZLowout+PCin. Repeat with `con_ff`=0 → T6 `ld`=0; next state T0 both times.
- st opcode 00010 → exactly one `ram_we` pulse, in T7; ld → Read asserted in T1 and T6 only.
- `clr` asserted during ld T5 → all outputs 0 the same cycle; after release, T0 resumes.
- halt opcode → `run` falls after T3 and stays low for 20 cycles; `stop` asserted during an add → HALT after T5.
- mul with `CU_MULDIV_EN` → HIin in T6. Without the macro → T3 idle, then T0.
